// File: rtl/adder_result_accum.sv
// Frame accumulator for ripple-carry adder results: sums COUNT {c_out,q} samples, counts carries.
// Optional ADDER_ACC_SATURATE_EN: clamp the accumulator at its maximum instead of wrapping.
module adder_result_accum #(
    parameter  int DATA_W = 4,
    parameter  int ACC_W  = 8,
    parameter  int COUNT  = 8,
    localparam int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_carries,
    output logic              out_ovf
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   carries;
    logic               ovf;
    logic               accept;
    logic               last;
    logic [ACC_W:0]     sample_ext;
    logic [ACC_W:0]     sum_wide;
    logic               sum_ovf;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    assign accept     = in_valid & in_ready & ~clear;
    assign last       = (cnt == CNT_LAST);
    assign sample_ext = {{(ACC_W - DATA_W){1'b0}}, in_carry, in_sum};
    assign sum_wide   = {1'b0, acc} + sample_ext;
    assign sum_ovf    = sum_wide[ACC_W];

    // The sum never decreases within a frame, so clamping on the carry-out is enough to stay pinned.
`ifdef ADDER_ACC_SATURATE_EN
    assign acc_next = sum_ovf ? ACC_MAX : sum_wide[ACC_W-1:0];
`else
    assign acc_next = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && last) state_next = HOLD;
            HOLD:    if (out_ready)      state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
        if (clear) state_next = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Frame registers restart on abort or on handoff of a held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            carries <= '0;
            ovf     <= 1'b0;
        end else if (clear || (state == HOLD && out_ready)) begin
            acc     <= '0;
            cnt     <= '0;
            carries <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            acc     <= acc_next;
            cnt     <= cnt + CNT_W'(1);
            carries <= carries + CNT_W'(in_carry);
            ovf     <= ovf | sum_ovf;
        end
    end

    assign out_acc     = acc;
    assign out_carries = carries;
    assign out_ovf     = ovf;

endmodule

// File: tb/tb_adder_result_accum.sv
// Self-checking bench: two instances (ACC_W=8 and ACC_W=6, COUNT=4) driven in lockstep,
// compared against a frame-level arithmetic model.
module tb_adder_result_accum;

    localparam int DATA_W = 4;
    localparam int COUNT  = 4;
    localparam int CNT_W  = $clog2(COUNT + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic in_valid;
    logic [DATA_W-1:0] in_sum;
    logic in_carry;
    logic out_ready;

    logic in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_acc8;
    logic [CNT_W-1:0] out_carries8;
    logic in_ready6, out_valid6, out_ovf6;
    logic [5:0] out_acc6;
    logic [CNT_W-1:0] out_carries6;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference: unbounded sum and counts of the current frame.
    int mSum     = 0;
    int mCarries = 0;
    int mCount   = 0;
    bit mHold    = 1'b0;

    always #5 clk = ~clk;

    adder_result_accum #(.DATA_W(DATA_W), .ACC_W(8), .COUNT(COUNT)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_acc(out_acc8), .out_carries(out_carries8), .out_ovf(out_ovf8)
    );

    adder_result_accum #(.DATA_W(DATA_W), .ACC_W(6), .COUNT(COUNT)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready6), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_acc(out_acc6), .out_carries(out_carries6), .out_ovf(out_ovf6)
    );

    function automatic int expAcc(input int sum, input int w);
        int maxVal;
        maxVal = (1 << w) - 1;
`ifdef ADDER_ACC_SATURATE_EN
        return (sum > maxVal) ? maxVal : sum;
`else
        return sum % (1 << w);
`endif
    endfunction

    function automatic int expOvf(input int sum, input int w);
        return (sum > ((1 << w) - 1)) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mSum = 0; mCarries = 0; mCount = 0; mHold = 1'b0;
    endtask

    task automatic compareAll();
        checkOutput("in_ready8",  {31'd0, in_ready8},  {31'd0, !mHold});
        checkOutput("in_ready6",  {31'd0, in_ready6},  {31'd0, !mHold});
        checkOutput("out_valid8", {31'd0, out_valid8}, {31'd0, mHold});
        checkOutput("out_valid6", {31'd0, out_valid6}, {31'd0, mHold});
        if (mHold) begin
            checkOutput("acc8",     32'(out_acc8),     32'(expAcc(mSum, 8)));
            checkOutput("acc6",     32'(out_acc6),     32'(expAcc(mSum, 6)));
            checkOutput("carries8", 32'(out_carries8), 32'(mCarries));
            checkOutput("carries6", 32'(out_carries6), 32'(mCarries));
            checkOutput("ovf8",     {31'd0, out_ovf8}, 32'(expOvf(mSum, 8)));
            checkOutput("ovf6",     {31'd0, out_ovf6}, 32'(expOvf(mSum, 6)));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input bit v, input logic [4:0] sample, input bit rdy, input bit clr);
        in_valid  = v;
        in_sum    = sample[3:0];
        in_carry  = sample[4];
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        if (clr) begin
            modelReset();
        end else if (!mHold) begin
            if (v) begin
                mSum     += int'(sample);
                mCarries += int'(sample[4]);
                mCount++;
                if (mCount == COUNT) mHold = 1'b1;
            end
        end else if (rdy) begin
            modelReset();
        end
        #1;
        compareAll();
    endtask

    initial begin
        logic [4:0] s;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;

        // Reset held across a clock edge.
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid8}, 32'd0);
        checkOutput("rst_out_acc",   32'(out_acc8),       32'd0);
        checkOutput("rst_out_ovf",   {31'd0, out_ovf8},   32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready",  {31'd0, in_ready8},  32'd1);

        // Accumulate a known frame.
        applyStimulus(1, 5'h05, 0, 0);
        applyStimulus(1, 5'h0A, 0, 0);
        applyStimulus(1, 5'h13, 0, 0);
        checkOutput("t2_not_yet", {31'd0, out_valid8}, 32'd0);
        applyStimulus(1, 5'h1F, 0, 0);
        checkOutput("t2_valid",   {31'd0, out_valid8}, 32'd1);
        checkOutput("t2_acc",     32'(out_acc8),       32'h41);
        checkOutput("t2_carries", 32'(out_carries8),   32'd2);
        checkOutput("t2_ovf",     {31'd0, out_ovf8},   32'd0);

        // Backpressure: held result ignores incoming samples.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 5'h07, 0, 0);
            checkOutput("t3_hold_acc", 32'(out_acc8), 32'h41);
        end
        applyStimulus(1, 5'h07, 1, 0);
        checkOutput("t3_in_ready", {31'd0, in_ready8}, 32'd1);

        // Overflow frame on the narrow instance.
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'h1F, 0, 0);
        checkOutput("t4_ovf6", {31'd0, out_ovf6}, 32'd1);
`ifdef ADDER_ACC_SATURATE_EN
        checkOutput("t4_acc6", 32'(out_acc6), 32'h3F);
`else
        checkOutput("t4_acc6", 32'(out_acc6), 32'h3C);
`endif
        applyStimulus(0, 5'h00, 1, 0);

        // Clear drops the partial frame and a coincident sample.
        applyStimulus(1, 5'h05, 0, 0);
        applyStimulus(1, 5'h05, 0, 0);
        applyStimulus(1, 5'h07, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'h01, 0, 0);
        checkOutput("t5_acc",     32'(out_acc8),     32'h04);
        checkOutput("t5_carries", 32'(out_carries8), 32'd0);

        // Asynchronous reset while holding a result.
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("t6_out_valid", {31'd0, out_valid8}, 32'd0);
        checkOutput("t6_in_ready",  {31'd0, in_ready8},  32'd1);
        checkOutput("t6_acc",       32'(out_acc8),       32'd0);
        #2;
        rst_n = 1'b1;

        // Randomised traffic with occasional aborts.
        for (int i = 0; i < 400; i++) begin
            s = 5'($urandom_range(0, 31));
            applyStimulus(bit'($urandom_range(0, 3) != 0), s,
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
